// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared widths and types for the ALU issue slice
//
// Purpose: datapath width, register index width, register count and the
//          opcode type used by alu_issue, its interface and its register file.
// Ports:   none (package).
// Config:  ALU_ISSUE_FORWARD_EN (used by alu_issue) enables operand forwarding.
package alu_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NREGS      = 8;

  typedef logic [1:0]            alu_op_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

endpackage

// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - instruction offer/accept handshake bundle
//
// Purpose: groups the instruction handshake between an instruction source
//          and alu_issue.
// Signals: in_valid  instruction offered
//          in_ready  instruction accepted on an edge with in_valid && in_ready
//          in_op     ALU opcode
//          in_rd     destination register index
//          in_rs1    source-0 register index
//          in_rs2    source-1 register index
// Modports: master (instruction source), slave (alu_issue).
interface alu_issue_if;
  import alu_pkg::*;

  logic      in_valid;
  logic      in_ready;
  alu_op_t   in_op;
  reg_addr_t in_rd;
  reg_addr_t in_rs1;
  reg_addr_t in_rs2;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2,
    output in_ready
  );

endinterface

// File: rtl/alu_issue_reg_file.sv
// rtl/alu_issue_reg_file.sv - NREGS x W register file, 3 async reads, 2 writes
//
// Purpose: general register storage for alu_issue.
// Ports:   clk, reset (async, active-low, clears every entry)
//          wa_en/wa_addr/wa_data  write port A (external load), wins on
//                                 same-address collision with port B
//          wb_en/wb_addr/wb_data  write port B (ALU writeback)
//          rs1_addr/rs1_data, rs2_addr/rs2_data, dbg_addr/dbg_data
//                                 combinational read ports
module reg_file #(
  parameter int NREGS = 8,
  parameter int W     = 16,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wa_en,
  input  logic [AW-1:0] wa_addr,
  input  logic [W-1:0]  wa_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [W-1:0]  wb_data,
  input  logic [AW-1:0] rs1_addr,
  output logic [W-1:0]  rs1_data,
  input  logic [AW-1:0] rs2_addr,
  output logic [W-1:0]  rs2_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data
);

  logic [W-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // Writeback is dropped only when the load targets the same entry.
      if (wb_en && !(wa_en && (wa_addr == wb_addr))) begin
        mem[wb_addr] <= wb_data;
      end
      if (wa_en) begin
        mem[wa_addr] <= wa_data;
      end
    end
  end

  assign rs1_data = mem[rs1_addr];
  assign rs2_data = mem[rs2_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - two-stage issue/writeback front end for an external ALU
//
// Purpose: accepts one instruction per cycle, registers opcode and operands
//          for an external combinational ALU, writes the ALU result and carry
//          back one edge later, and stalls or forwards on a read-after-write
//          hazard against the instruction in writeback.
// Ports:   clk, reset (async, active-low)
//          issue       alu_issue_if.slave instruction handshake
//          op, i0, i1  registered opcode/operands to the ALU
//          o, cout     ALU result and carry (combinational from op/i0/i1)
//          carry_flag  cout captured at the last writeback
//          ld_en/ld_addr/ld_data  external register load (blocks issue)
//          dbg_addr/dbg_data      combinational register read
// Config:  ALU_ISSUE_FORWARD_EN - when defined, hazarding operands take o
//          directly and issue never stalls on a hazard; otherwise a hazard
//          holds in_ready low for one cycle.
module alu_issue
  import alu_pkg::*;
#(
  parameter int NREGS = alu_pkg::NREGS,
  parameter int W     = alu_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  alu_issue_if.slave   issue,
  output alu_op_t      op,
  output logic [W-1:0] i0,
  output logic [W-1:0] i1,
  input  logic [W-1:0] o,
  input  logic         cout,
  output logic         carry_flag,
  input  logic         ld_en,
  input  reg_addr_t    ld_addr,
  input  logic [W-1:0] ld_data,
  input  reg_addr_t    dbg_addr,
  output logic [W-1:0] dbg_data
);

  logic         wb_valid;
  reg_addr_t    wb_rd;
  logic [W-1:0] rs1_data;
  logic [W-1:0] rs2_data;
  logic [W-1:0] opnd0;
  logic [W-1:0] opnd1;
  logic         hazard_rs1;
  logic         hazard_rs2;
  logic         ready;
  logic         accept;

  reg_file #(
    .NREGS (NREGS),
    .W     (W),
    .AW    (REG_ADDR_W)
  ) u_reg_file (
    .clk      (clk),
    .reset    (reset),
    .wa_en    (ld_en),
    .wa_addr  (ld_addr),
    .wa_data  (ld_data),
    .wb_en    (wb_valid),
    .wb_addr  (wb_rd),
    .wb_data  (o),
    .rs1_addr (issue.in_rs1),
    .rs1_data (rs1_data),
    .rs2_addr (issue.in_rs2),
    .rs2_data (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // The instruction in writeback has not reached the register file yet.
  assign hazard_rs1 = wb_valid && (issue.in_rs1 == wb_rd);
  assign hazard_rs2 = wb_valid && (issue.in_rs2 == wb_rd);

`ifdef ALU_ISSUE_FORWARD_EN
  // o is exactly the value being written this edge, so it can stand in for
  // the stale register. A load to the same entry cannot coincide: ld_en
  // blocks issue.
  assign opnd0 = hazard_rs1 ? o : rs1_data;
  assign opnd1 = hazard_rs2 ? o : rs2_data;
  assign ready = !ld_en;
`else
  logic hazard;
  assign hazard = hazard_rs1 || hazard_rs2;
  assign opnd0  = rs1_data;
  assign opnd1  = rs2_data;
  // One stall cycle lets the writeback land; the reissue then reads it.
  assign ready  = !ld_en && !hazard;
`endif

  // Ready is deliberately independent of in_valid.
  assign issue.in_ready = ready;
  assign accept         = issue.in_valid && ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op         <= '0;
      i0         <= '0;
      i1         <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      carry_flag <= 1'b0;
    end else begin
      wb_valid <= accept;
      if (accept) begin
        op    <= issue.in_op;
        i0    <= opnd0;
        i1    <= opnd1;
        wb_rd <= issue.in_rd;
      end
      if (wb_valid) begin
        carry_flag <= cout;
      end
    end
  end

endmodule
